// File: rtl/mux_select_sequencer.sv
// mux_select_sequencer: round-robin scan controller for a 4:1 mux.
// Selects each enabled channel in turn and holds it for one settle cycle
// plus a programmable dwell. It then captures the mux output Y into that
// channel's bit of the sample register.
// Optional feature macro: MUXSEQ_SWEEP_CNT_EN adds sweep_done / sweep_cnt.
module mux_select_sequencer #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y_in,
  output logic               sel_a,
  output logic               sel_b,
  output logic [1:0]         ch_idx,
  output logic               busy,
  output logic               sample_valid,
  output logic [3:0]         samples
`ifdef MUXSEQ_SWEEP_CNT_EN
  ,
  output logic               sweep_done,
  output logic [7:0]         sweep_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [1:0]         r_ch;
  logic [1:0]         w_nextCh;
  logic [1:0]         w_lowIdx;
  logic [1:0]         w_pickIdx;
  logic               w_pickFound;
  logic               w_capture;
  logic               w_endScan;
  logic               w_wrap;
  logic               w_stopReq;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_nextCnt;
  logic               r_stop;
  logic               r_busy;
  logic               r_valid;
  logic [3:0]         r_samples;

  // A stop raised in the capture cycle itself also ends the scan.
  assign w_stopReq = r_stop | stop;

  // Lowest enabled channel is the first channel of a new scan.
  always_comb begin
    w_lowIdx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) w_lowIdx = 2'(i);
    end
  end

  // Round-robin pick: the closest enabled channel after the current one (offset +4 wraps to itself).
  always_comb begin
    w_pickFound = 1'b0;
    w_pickIdx   = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      if (ch_mask[r_ch + 2'(k)]) begin
        w_pickFound = 1'b1;
        w_pickIdx   = r_ch + 2'(k);
      end
    end
  end

  // Next-state logic: accepts start, settles, counts dwell down and then captures and advances.
  always_comb begin
    w_nextState = r_state;
    w_nextCh    = r_ch;
    w_nextCnt   = r_cnt;
    w_capture   = 1'b0;
    w_endScan   = 1'b0;
    w_wrap      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && (|ch_mask) && !stop) begin
          w_nextState = SETTLE;
          w_nextCh    = w_lowIdx;
        end
      end
      SETTLE: begin
        w_nextCnt   = dwell;
        w_nextState = DWELL;
      end
      DWELL: begin
        if (r_cnt != '0) begin
          w_nextCnt = r_cnt - 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_stopReq || !w_pickFound) begin
            w_endScan   = 1'b1;
            w_nextState = IDLE;
            w_nextCh    = 2'd0;
          end else begin
            w_wrap      = (w_pickIdx <= r_ch);
            w_nextState = SETTLE;
            w_nextCh    = w_pickIdx;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCh    = 2'd0;
      end
    endcase
  end

  // State, channel, dwell counter, stop latch and sample registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ch      <= 2'd0;
      r_cnt     <= '0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_samples <= 4'b0000;
    end else begin
      r_state <= w_nextState;
      r_ch    <= w_nextCh;
      r_cnt   <= w_nextCnt;
      r_busy  <= (w_nextState != IDLE);
      r_valid <= w_capture;
      if (w_capture) r_samples[r_ch] <= y_in;
      if (w_nextState == IDLE) begin
        r_stop <= 1'b0;
      end else if (r_state != IDLE && stop) begin
        r_stop <= 1'b1;
      end
    end
  end

  assign sel_a        = r_ch[0];
  assign sel_b        = r_ch[1];
  assign ch_idx       = r_ch;
  assign busy         = r_busy;
  assign sample_valid = r_valid;
  assign samples      = r_samples;

`ifdef MUXSEQ_SWEEP_CNT_EN
  logic       w_sweep;
  logic       r_sweepDone;
  logic [7:0] r_sweepCnt;

  assign w_sweep = w_capture & (w_endScan | w_wrap);

  // Sweep pulse and counter; a sweep ends on a wrapping pick or when the scan ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sweepDone <= 1'b0;
      r_sweepCnt  <= 8'd0;
    end else begin
      r_sweepDone <= w_sweep;
      if (w_sweep) r_sweepCnt <= r_sweepCnt + 8'd1;
    end
  end

  assign sweep_done = r_sweepDone;
  assign sweep_cnt  = r_sweepCnt;
`endif

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Testbench for mux_select_sequencer: directed vector table, hand sequences,
// and randomized stimulus checked against a channel-level reference model.
module tb_mux_select_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] ch_mask;
  logic [3:0] dwell;
  logic       y_in;
  logic       sel_a;
  logic       sel_b;
  logic [1:0] ch_idx;
  logic       busy;
  logic       sample_valid;
  logic [3:0] samples;
`ifdef MUXSEQ_SWEEP_CNT_EN
  logic       sweep_done;
  logic [7:0] sweep_cnt;
`endif

  int testsRun;
  int testsFailed;

  mux_select_sequencer #(.DWELL_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .ch_mask      (ch_mask),
    .dwell        (dwell),
    .y_in         (y_in),
    .sel_a        (sel_a),
    .sel_b        (sel_b),
    .ch_idx       (ch_idx),
    .busy         (busy),
    .sample_valid (sample_valid),
    .samples      (samples)
`ifdef MUXSEQ_SWEEP_CNT_EN
    ,
    .sweep_done   (sweep_done),
    .sweep_cnt    (sweep_cnt)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a scan visits channels, each lasting (dwell latched one edge after entry) + 2 edges.
  bit         mBusy;
  int         mCh;
  int         mAge;
  int         mDwell;
  bit         mStopL;
  logic [3:0] mSamples;
  bit         mValid;
  bit         mSweep;
  int         mSweepCnt;
  int         mSweepTotal;

  task automatic modelReset();
    mBusy = 0; mCh = 0; mAge = 0; mDwell = 0; mStopL = 0;
    mSamples = 4'b0000; mValid = 0; mSweep = 0; mSweepCnt = 0; mSweepTotal = 0;
  endtask

  task automatic modelStep(input logic iStart, input logic iStop, input logic [3:0] iMask,
                           input logic [3:0] iDwell, input logic iY);
    int  nxt;
    bit  found;
    mValid = 0;
    mSweep = 0;
    if (!mBusy) begin
      mStopL = 0;
      if (iStart && iMask != 4'b0000 && !iStop) begin
        mBusy = 1;
        mAge  = 0;
        mCh   = 0;
        while (!iMask[mCh]) mCh++;
      end
    end else begin
      if (iStop) mStopL = 1;
      mAge++;
      if (mAge == 1) begin
        mDwell = int'(iDwell);
      end else if (mAge == mDwell + 2) begin
        mSamples[mCh] = iY;
        mValid = 1;
        found = 0;
        nxt = 0;
        for (int k = 1; k <= 4; k++) begin
          if (!found && iMask[(mCh + k) % 4]) begin
            found = 1;
            nxt = (mCh + k) % 4;
          end
        end
        if (mStopL || !found) begin
          mSweep = 1;
          mBusy = 0;
          mCh = 0;
        end else begin
          mSweep = (nxt <= mCh);
          mCh = nxt;
          mAge = 0;
        end
        if (mSweep) begin
          mSweepCnt = (mSweepCnt + 1) % 256;
          mSweepTotal++;
        end
      end
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    checkVal({tag, ".busy"}, int'(busy), int'(mBusy));
    checkVal({tag, ".ch_idx"}, int'(ch_idx), mCh);
    checkVal({tag, ".sel_a"}, int'(sel_a), mCh % 2);
    checkVal({tag, ".sel_b"}, int'(sel_b), mCh / 2);
    checkVal({tag, ".sample_valid"}, int'(sample_valid), int'(mValid));
    checkVal({tag, ".samples"}, int'(samples), int'(mSamples));
`ifdef MUXSEQ_SWEEP_CNT_EN
    checkVal({tag, ".sweep_done"}, int'(sweep_done), int'(mSweep));
    checkVal({tag, ".sweep_cnt"}, int'(sweep_cnt), mSweepCnt);
`endif
  endtask

  // Drive inputs for one cycle (from a negedge), advance the model at the posedge, return at the next negedge.
  task automatic applyStimulus(input logic iStart, input logic iStop, input logic [3:0] iMask,
                               input logic [3:0] iDwell, input logic iY);
    start = iStart; stop = iStop; ch_mask = iMask; dwell = iDwell; y_in = iY;
    @(posedge clk);
    modelStep(iStart, iStop, iMask, iDwell, iY);
    @(negedge clk);
  endtask

  task automatic doReset();
    start = 0; stop = 0; ch_mask = 4'b0000; dwell = 4'd0; y_in = 0;
    rst_n = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic       st;
    logic       sp;
    logic [3:0] m;
    logic [3:0] d;
    logic       y;
    logic       eBusy;
    logic [1:0] eCh;
    logic       eValid;
    logic [3:0] eSamp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int  steps;
    int  pulses;
    logic rs, rp, ry;
    logic [3:0] rm, rd;

    testsRun = 0;
    testsFailed = 0;
    rst_n = 1'b0;
    start = 0; stop = 0; ch_mask = 4'b0000; dwell = 4'd0; y_in = 0;

    // mask=1111 dwell=0, y_in = channel pattern c0=0,c1=1,c2=0,c3=1; ends with stop and IDLE starts.
    vecs[0]  = '{1'b1, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000};
    vecs[1]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 2'd0, 1'b0, 4'b0000};
    vecs[2]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0000};
    vecs[3]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b1, 1'b1, 2'd1, 1'b0, 4'b0000};
    vecs[4]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0010};
    vecs[5]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0010};
    vecs[6]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b1, 2'd3, 1'b1, 4'b0010};
    vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b1, 1'b1, 2'd3, 1'b0, 4'b0010};
    vecs[8]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b1, 1'b1, 2'd0, 1'b1, 4'b1010};
    vecs[9]  = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b1, 1'b1, 2'd0, 1'b0, 4'b1010};
    vecs[10] = '{1'b0, 1'b1, 4'hF, 4'd0, 1'b1, 1'b0, 2'd0, 1'b1, 4'b1011};
    vecs[11] = '{1'b0, 1'b0, 4'hF, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1011};
    vecs[12] = '{1'b1, 1'b1, 4'hF, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1011};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 4'b1011};

    // Reset state.
    doReset();
    checkVal("reset.busy", int'(busy), 0);
    checkVal("reset.ch_idx", int'(ch_idx), 0);
    checkVal("reset.valid", int'(sample_valid), 0);
    checkVal("reset.samples", int'(samples), 0);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].st, vecs[i].sp, vecs[i].m, vecs[i].d, vecs[i].y);
      checkVal($sformatf("vec%0d.busy", i), int'(busy), int'(vecs[i].eBusy));
      checkVal($sformatf("vec%0d.ch_idx", i), int'(ch_idx), int'(vecs[i].eCh));
      checkVal($sformatf("vec%0d.sel", i), int'({sel_b, sel_a}), int'(vecs[i].eCh));
      checkVal($sformatf("vec%0d.valid", i), int'(sample_valid), int'(vecs[i].eValid));
      checkVal($sformatf("vec%0d.samples", i), int'(samples), int'(vecs[i].eSamp));
      checkOutput($sformatf("vec%0d.model", i));
    end

    // mask=1010, dwell=3: only channels 1 and 3, five cycles each; y_in=1 on ch1 only.
    doReset();
    applyStimulus(1, 0, 4'b1010, 4'd3, 0);
    checkVal("sparse.first", int'(ch_idx), 1);
    for (int s = 1; s <= 20; s++) begin
      applyStimulus(0, 0, 4'b1010, 4'd3, (mCh == 1));
      checkOutput($sformatf("sparse%0d", s));
      if (s == 4)  checkVal("sparse.hold1", int'(ch_idx), 1);
      if (s == 5)  checkVal("sparse.to3", int'(ch_idx), 3);
      if (s == 9)  checkVal("sparse.hold3", int'(ch_idx), 3);
      if (s == 10) checkVal("sparse.wrap1", int'(ch_idx), 1);
    end
    checkVal("sparse.samples", int'(samples), 4'b0010);

    // stop pulsed mid-DWELL of ch2 (mask=1111, dwell=3): ch2 still captured, then IDLE; restart at ch0.
    doReset();
    applyStimulus(1, 0, 4'hF, 4'd3, 0);
    for (int s = 1; s <= 12; s++) applyStimulus(0, 0, 4'hF, 4'd3, 0);
    checkVal("stop.onCh2", int'(ch_idx), 2);
    applyStimulus(0, 1, 4'hF, 4'd3, 0);
    applyStimulus(0, 0, 4'hF, 4'd3, 0);
    checkVal("stop.stillBusy", int'(busy), 1);
    applyStimulus(0, 0, 4'hF, 4'd3, 1);
    checkVal("stop.idle", int'(busy), 0);
    checkVal("stop.sel", int'({sel_b, sel_a}), 0);
    checkVal("stop.valid", int'(sample_valid), 1);
    checkVal("stop.ch2Sample", int'(samples[2]), 1);
    checkOutput("stop.model");
    applyStimulus(0, 0, 4'hF, 4'd3, 0);
    checkVal("stop.stayIdle", int'(busy), 0);
    applyStimulus(1, 0, 4'hF, 4'd3, 0);
    checkVal("stop.restartBusy", int'(busy), 1);
    checkVal("stop.restartCh0", int'(ch_idx), 0);

    // Asynchronous reset during DWELL of ch3: outputs clear before the next clock edge.
    doReset();
    applyStimulus(1, 0, 4'hF, 4'd5, 1);
    steps = 0;
    while (!(mBusy && mCh == 3 && mAge >= 2) && steps < 200) begin
      applyStimulus(0, 0, 4'hF, 4'd5, 1);
      steps++;
    end
    checkVal("areset.reachedCh3Dwell", int'(steps < 200), 1);
    checkVal("areset.preSamples", int'(samples), 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    checkVal("areset.busy", int'(busy), 0);
    checkVal("areset.ch_idx", int'(ch_idx), 0);
    checkVal("areset.samples", int'(samples), 0);
    checkVal("areset.valid", int'(sample_valid), 0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized stimulus against the reference model.
    rm = 4'hF;
    for (int s = 0; s < 3000; s++) begin
      rs = ($urandom_range(0, 3) == 0);
      rp = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 15) == 0) rm = 4'($urandom_range(0, 15));
      rd = 4'($urandom_range(0, 3));
      ry = 1'($urandom_range(0, 1));
      applyStimulus(rs, rp, rm, rd, ry);
      checkOutput($sformatf("rand%0d", s));
    end

`ifdef MUXSEQ_SWEEP_CNT_EN
    // mask=0101, dwell=0: a sweep ends on every ch2 capture; 256 sweeps wrap the counter.
    doReset();
    pulses = 0;
    steps = 0;
    applyStimulus(1, 0, 4'b0101, 4'd0, 0);
    while (mSweepTotal < 256 && steps < 4000) begin
      applyStimulus(0, 0, 4'b0101, 4'd0, 1);
      checkOutput($sformatf("sweep%0d", steps));
      if (sweep_done) begin
        pulses++;
        checkVal("sweep.onCh2Capture", int'(sample_valid && ch_idx == 2'd0), 1);
      end
      steps++;
    end
    checkVal("sweep.finished", int'(steps < 4000), 1);
    checkVal("sweep.pulses", pulses, 256);
    checkVal("sweep.cntWrap", int'(sweep_cnt), 0);
`else
    pulses = 0;
    steps = pulses;
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
